mem_bus_ctrl: RTL and testbench

Data-side memory controller sitting directly downstream of the CPU core's load/store port. It consumes the core's `read`/`write` strobes, address and write data. It decodes each access to an internal word-addressed data RAM or a small memory-mapped I/O page (LEDs, switches, cycle counter, status), and returns registered read data with a one-cycle valid pulse.

---
 rtl/mem_bus_ctrl.sv | 105 ++++++++++
 tb/tb_mem_bus_ctrl.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/mem_bus_ctrl.sv
// Data-side memory controller: word RAM plus a small MMIO page
// (LEDs, switches, cycle counter, sticky status) behind the core's load/store port.
module mem_bus_ctrl #(
  parameter int ADDR_W    = 8,
  parameter int DATA_W    = 32,
  parameter int RAM_DEPTH = 128,
  parameter int LED_W     = 8,
  parameter int SW_W      = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              read,
  input  logic              write,
  input  logic [ADDR_W-1:0] address,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata,
  output logic              rvalid,
  output logic [LED_W-1:0]  leds,
  input  logic [SW_W-1:0]   sw
);

  localparam int AW = (RAM_DEPTH > 1) ? $clog2(RAM_DEPTH) : 1;

  localparam logic [ADDR_W-1:0] A_LED = ADDR_W'(8'hF0);
  localparam logic [ADDR_W-1:0] A_SW  = ADDR_W'(8'hF1);
  localparam logic [ADDR_W-1:0] A_CNT = ADDR_W'(8'hF2);
  localparam logic [ADDR_W-1:0] A_ST  = ADDR_W'(8'hF3);

  logic [DATA_W-1:0] mem [RAM_DEPTH];
  logic [DATA_W-1:0] cnt;
  logic [1:0]        status;
  logic [SW_W-1:0]   sw_s1;
  logic [SW_W-1:0]   sw_s2;

  logic [AW-1:0]     idx;
  logic              is_ram;
  logic              is_led;
  logic              is_sw;
  logic              is_cnt;
  logic              is_st;
  logic              unmapped;
  logic              rd_ok;
  logic [1:0]        st_set;
  logic [1:0]        st_clr;
  logic [DATA_W-1:0] rd_mux;

  assign idx      = address[AW-1:0];
  assign is_ram   = 32'(address) < 32'(RAM_DEPTH);
  assign is_led   = address == A_LED;
  assign is_sw    = address == A_SW;
  assign is_cnt   = address == A_CNT;
  assign is_st    = address == A_ST;
  assign unmapped = !(is_ram || is_led || is_sw || is_cnt || is_st);

  // A colliding read is dropped; the write side always proceeds.
  assign rd_ok = read && !write;

  assign st_set = {read && write, (read || write) && unmapped};
  assign st_clr = (write && is_st) ? wdata[1:0] : 2'b00;

  always_comb begin
    rd_mux = '0;
    unique case (1'b1)
      is_ram:  rd_mux = mem[idx];
      is_led:  rd_mux = DATA_W'(leds);
      is_sw:   rd_mux = DATA_W'(sw_s2);
      is_cnt:  rd_mux = cnt;
      is_st:   rd_mux = DATA_W'(status);
      default: rd_mux = '0;
    endcase
  end

  // RAM contents survive reset.
  always_ff @(posedge clk) begin
    if (!rst && write && is_ram) begin
      mem[idx] <= wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rdata  <= '0;
      rvalid <= 1'b0;
      leds   <= '0;
      cnt    <= '0;
      status <= 2'b00;
      sw_s1  <= '0;
      sw_s2  <= '0;
    end else begin
      sw_s1  <= sw;
      sw_s2  <= sw_s1;
      rvalid <= rd_ok;
      if (rd_ok) begin
        rdata <= rd_mux;
      end
      if (write && is_led) begin
        leds <= wdata[LED_W-1:0];
      end
      cnt    <= (write && is_cnt) ? wdata : cnt + DATA_W'(1);
      // New error events win over a same-cycle clear.
      status <= (status & ~st_clr) | st_set;
    end
  end

endmodule

// File: tb/tb_mem_bus_ctrl.sv
// Bench for mem_bus_ctrl: directed checks from the test plan,
// then random bus traffic against a behavioural model of the memory map.
module tb_mem_bus_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        read;
  logic        write;
  logic [7:0]  address;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        rvalid;
  logic [7:0]  leds;
  logic [7:0]  sw;

  int n_chk  = 0;
  int n_pass = 0;

  logic [31:0] m_ram [128];
  logic [31:0] m_rdata;
  logic        m_rvalid;
  logic [7:0]  m_leds;
  logic [31:0] m_cnt;
  logic [1:0]  m_status;
  logic [7:0]  m_hist1;
  logic [7:0]  m_hist2;

  mem_bus_ctrl dut (
    .clk     (clk),
    .rst     (rst),
    .read    (read),
    .write   (write),
    .address (address),
    .wdata   (wdata),
    .rdata   (rdata),
    .rvalid  (rvalid),
    .leds    (leds),
    .sw      (sw)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_chk++;
    if (got === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_rdata  = '0;
    m_rvalid = 1'b0;
    m_leds   = '0;
    m_cnt    = '0;
    m_status = 2'b00;
    m_hist1  = '0;
    m_hist2  = '0;
  endtask

  // One clock edge of the memory map as seen by software.
  task automatic model_edge(input bit rd, input bit wr,
                            input logic [7:0] a, input logic [31:0] d);
    int          ai;
    logic [31:0] v;
    bit          unm;
    logic [1:0]  clr;
    ai  = int'(a);
    unm = 1'b0;
    if (ai < 128)       v = m_ram[ai];
    else if (ai == 240) v = {24'h0, m_leds};
    else if (ai == 241) v = {24'h0, m_hist2};
    else if (ai == 242) v = m_cnt;
    else if (ai == 243) v = {30'h0, m_status};
    else begin
      v   = 32'h0;
      unm = 1'b1;
    end
    m_rvalid = rd && !wr;
    if (m_rvalid) m_rdata = v;
    if (wr && ai < 128) m_ram[ai] = d;
    if (wr && ai == 240) m_leds = d[7:0];
    if (wr && ai == 242) m_cnt = d;
    else m_cnt = m_cnt + 32'd1;
    clr = (wr && ai == 243) ? d[1:0] : 2'b00;
    m_status = (m_status & ~clr) | {rd && wr, (rd || wr) && unm};
    m_hist2 = m_hist1;
    m_hist1 = sw;
  endtask

  // Drive one bus cycle from a negedge, then check at the next negedge.
  task automatic bus(input bit rd, input bit wr,
                     input logic [7:0] a, input logic [31:0] d);
    read    = rd;
    write   = wr;
    address = a;
    wdata   = d;
    model_edge(rd, wr, a, d);
    @(negedge clk);
    check("rvalid", 32'(rvalid), 32'(m_rvalid));
    check("rdata", rdata, m_rdata);
    check("leds", 32'(leds), 32'(m_leds));
  endtask

  task automatic idle();
    bus(1'b0, 1'b0, 8'h00, 32'h0);
  endtask

  initial begin
    logic [7:0]  a;
    logic [31:0] d;
    int          r;
    int          k;

    rst = 1'b1; read = 1'b0; write = 1'b0;
    address = '0; wdata = '0; sw = '0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    check("rst_rvalid", 32'(rvalid), 32'h0);
    check("rst_rdata", rdata, 32'h0);
    check("rst_leds", 32'(leds), 32'h0);

    idle(); idle(); idle();
    bus(1'b1, 1'b0, 8'hF2, 32'h0);
    check("cnt_after_rst", rdata, 32'd3);
    check("cnt_rvalid", 32'(rvalid), 32'h1);

    for (int i = 0; i < 128; i++) begin
      bus(1'b0, 1'b1, 8'(i), $urandom);
    end

    bus(1'b0, 1'b1, 8'd5, 32'hDEADBEEF);
    bus(1'b1, 1'b0, 8'd5, 32'h0);
    check("raw_rd5", rdata, 32'hDEADBEEF);
    idle();
    check("pulse_single", 32'(rvalid), 32'h0);
    bus(1'b0, 1'b1, 8'd6, 32'h1);
    bus(1'b1, 1'b0, 8'd5, 32'h0);
    check("b2b_rd5", rdata, 32'hDEADBEEF);
    bus(1'b1, 1'b0, 8'd6, 32'h0);
    check("b2b_rd6", rdata, 32'h1);
    check("b2b_rv6", 32'(rvalid), 32'h1);

    bus(1'b0, 1'b1, 8'hF0, 32'h1A5);
    check("led_out", 32'(leds), 32'hA5);
    bus(1'b1, 1'b0, 8'hF0, 32'h0);
    check("led_rd", rdata, 32'h000000A5);

    sw = 8'h3C;
    idle(); idle();
    bus(1'b1, 1'b0, 8'hF1, 32'h0);
    check("sw_rd", rdata, 32'h3C);
    bus(1'b0, 1'b1, 8'hF1, 32'h55);
    bus(1'b1, 1'b0, 8'hF3, 32'h0);
    check("sw_wr_noerr", rdata, 32'h0);

    bus(1'b0, 1'b1, 8'hF2, 32'hFFFFFFFE);
    idle();
    bus(1'b1, 1'b0, 8'hF2, 32'h0);
    check("cnt_max", rdata, 32'hFFFFFFFF);
    bus(1'b1, 1'b0, 8'hF2, 32'h0);
    check("cnt_wrap", rdata, 32'h0);

    bus(1'b1, 1'b0, 8'h80, 32'h0);
    check("unm_rdata", rdata, 32'h0);
    check("unm_rvalid", 32'(rvalid), 32'h1);
    bus(1'b1, 1'b0, 8'hF3, 32'h0);
    check("st_unm", rdata, 32'h1);
    bus(1'b1, 1'b1, 8'd3, 32'd7);
    check("coll_rvalid", 32'(rvalid), 32'h0);
    bus(1'b1, 1'b0, 8'hF3, 32'h0);
    check("st_coll", rdata, 32'h3);
    bus(1'b1, 1'b0, 8'd3, 32'h0);
    check("coll_ram3", rdata, 32'd7);
    bus(1'b0, 1'b1, 8'hF3, 32'h1);
    bus(1'b1, 1'b0, 8'hF3, 32'h0);
    check("st_w1c", rdata, 32'h2);
    bus(1'b0, 1'b1, 8'hF3, 32'h2);
    bus(1'b1, 1'b1, 8'hF3, 32'h3);
    bus(1'b1, 1'b0, 8'hF3, 32'h0);
    check("st_set_wins", rdata, 32'h2);

    for (int i = 0; i < 3000; i++) begin
      r = $urandom_range(0, 99);
      k = $urandom_range(0, 9);
      if (k < 6) a = 8'($urandom_range(0, 127));
      else if (k < 9) a = 8'(8'hF0 + $urandom_range(0, 3));
      else if ($urandom_range(0, 1) == 0) a = 8'($urandom_range(128, 239));
      else a = 8'($urandom_range(244, 255));
      d = $urandom;
      if (i % 17 == 0) sw = 8'($urandom);
      bus(r < 45, r >= 35 && r < 70, a, d);
    end

    bus(1'b0, 1'b1, 8'd5, 32'h12345678);
    read = 1'b1; write = 1'b0; address = 8'd5; rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    check("rst_mid_rvalid", 32'(rvalid), 32'h0);
    check("rst_mid_rdata", rdata, 32'h0);
    idle();
    check("rst_mid_none", 32'(rvalid), 32'h0);
    bus(1'b1, 1'b0, 8'd5, 32'h0);
    check("ram_kept", rdata, 32'h12345678);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
